// File: rtl/spi_target.sv
// SPI mode-0 target: synchronises SCK/SS_N/MOSI into CLK, shifts bytes in on SCK rise
// and out on SCK fall, with a one-entry transmit holding register.
module spi_target #(
   parameter int         SYNC_STAGES = 2,
   parameter logic [7:0] IDLE_BYTE   = 8'hFF
) (
   input  logic       CLK,
   input  logic       reset,
   input  logic       spi_sck,
   input  logic       spi_ss_n,
   input  logic       spi_mosi,
   output logic       spi_miso,
   output logic       spi_miso_oe,
   input  logic [7:0] tx_data,
   input  logic       tx_valid,
   output logic       tx_ready,
   output logic [7:0] rx_data,
   output logic       rx_valid,
   output logic       tx_underrun,
   output logic       busy
);

   // state  | meaning
   // IDLE   | not selected; SCK edges ignored, waiting for a select fall
   // ACTIVE | selected; shifting on SCK edges until select rises
   typedef enum logic {S_IDLE, S_ACTIVE} state_t;

   state_t                 state_q, state_d;
   logic [SYNC_STAGES-1:0] sck_sync_q, sck_sync_d;
   logic [SYNC_STAGES-1:0] ss_sync_q, ss_sync_d;
   logic [SYNC_STAGES-1:0] mosi_sync_q, mosi_sync_d;
   logic                   sck_dly_q, sck_dly_d;
   logic                   ss_dly_q, ss_dly_d;
   logic                   mosi_dly_q, mosi_dly_d;
   logic                   sck_rise_q, sck_rise_d;
   logic                   sck_fall_q, sck_fall_d;
   logic                   ss_fall_q, ss_fall_d;
   logic                   ss_rise_q, ss_rise_d;
   logic [2:0]             bit_cnt_q, bit_cnt_d;
   logic [7:0]             rx_shift_q, rx_shift_d;
   logic [7:0]             tx_shift_q, tx_shift_d;
   logic                   byte_done_q, byte_done_d;
   logic [7:0]             rx_data_q, rx_data_d;
   logic                   rx_valid_q, rx_valid_d;
   logic                   tx_underrun_q, tx_underrun_d;
   logic [7:0]             hold_q, hold_d;
   logic                   hold_full_q, hold_full_d;

   logic sck_s, ss_s, mosi_s;
   logic load, wr;

   assign sck_s  = sck_sync_q[SYNC_STAGES-1];
   assign ss_s   = ss_sync_q[SYNC_STAGES-1];
   assign mosi_s = mosi_sync_q[SYNC_STAGES-1];
   assign wr     = tx_valid & ~hold_full_q;

   always_comb begin
      state_d       = state_q;
      bit_cnt_d     = bit_cnt_q;
      rx_shift_d    = rx_shift_q;
      tx_shift_d    = tx_shift_q;
      byte_done_d   = byte_done_q;
      rx_data_d     = rx_data_q;
      rx_valid_d    = 1'b0;
      tx_underrun_d = 1'b0;
      load          = 1'b0;

      sck_sync_d  = {sck_sync_q[SYNC_STAGES-2:0], spi_sck};
      ss_sync_d   = {ss_sync_q[SYNC_STAGES-2:0], spi_ss_n};
      mosi_sync_d = {mosi_sync_q[SYNC_STAGES-2:0], spi_mosi};
      sck_dly_d   = sck_s;
      ss_dly_d    = ss_s;
      mosi_dly_d  = mosi_s;
      sck_rise_d  = sck_s & ~sck_dly_q;
      sck_fall_d  = ~sck_s & sck_dly_q;
      // select chain resets low, so a fall is only seen after a genuine high
      ss_fall_d   = ~ss_s & ss_dly_q;
      ss_rise_d   = ss_s & ~ss_dly_q;

      case (state_q)
         S_IDLE: begin
            if (ss_fall_q) begin
               state_d     = S_ACTIVE;
               bit_cnt_d   = 3'd0;
               byte_done_d = 1'b0;
               load        = 1'b1;
            end
         end
         S_ACTIVE: begin
            if (ss_rise_q) begin
               state_d     = S_IDLE;
               rx_shift_d  = 8'h00;
               bit_cnt_d   = 3'd0;
               byte_done_d = 1'b0;
            end else if (sck_rise_q) begin
               rx_shift_d = {rx_shift_q[6:0], mosi_dly_q};
               bit_cnt_d  = bit_cnt_q + 3'd1;
               if (bit_cnt_q == 3'd7) begin
                  rx_data_d   = {rx_shift_q[6:0], mosi_dly_q};
                  rx_valid_d  = 1'b1;
                  byte_done_d = 1'b1;
               end
            end else if (sck_fall_q) begin
               if (byte_done_q) begin
                  load        = 1'b1;
                  byte_done_d = 1'b0;
               end else begin
                  tx_shift_d = {tx_shift_q[6:0], 1'b0};
               end
            end
         end
         default: state_d = S_IDLE;
      endcase

      if (load) begin
         if (hold_full_q) begin
            tx_shift_d = hold_q;
         end else begin
            tx_shift_d    = IDLE_BYTE;
            tx_underrun_d = 1'b1;
         end
      end

      // a write coinciding with a load fills the register for the following byte
      hold_d      = wr ? tx_data : hold_q;
      hold_full_d = wr | (hold_full_q & ~load);
   end

   always_ff @(posedge CLK) begin
      if (reset) begin
         state_q       <= S_IDLE;
         sck_sync_q    <= '0;
         ss_sync_q     <= '0;
         mosi_sync_q   <= '0;
         sck_dly_q     <= 1'b0;
         ss_dly_q      <= 1'b0;
         mosi_dly_q    <= 1'b0;
         sck_rise_q    <= 1'b0;
         sck_fall_q    <= 1'b0;
         ss_fall_q     <= 1'b0;
         ss_rise_q     <= 1'b0;
         bit_cnt_q     <= 3'd0;
         rx_shift_q    <= 8'h00;
         tx_shift_q    <= IDLE_BYTE;
         byte_done_q   <= 1'b0;
         rx_data_q     <= 8'h00;
         rx_valid_q    <= 1'b0;
         tx_underrun_q <= 1'b0;
         hold_q        <= 8'h00;
         hold_full_q   <= 1'b0;
      end else begin
         state_q       <= state_d;
         sck_sync_q    <= sck_sync_d;
         ss_sync_q     <= ss_sync_d;
         mosi_sync_q   <= mosi_sync_d;
         sck_dly_q     <= sck_dly_d;
         ss_dly_q      <= ss_dly_d;
         mosi_dly_q    <= mosi_dly_d;
         sck_rise_q    <= sck_rise_d;
         sck_fall_q    <= sck_fall_d;
         ss_fall_q     <= ss_fall_d;
         ss_rise_q     <= ss_rise_d;
         bit_cnt_q     <= bit_cnt_d;
         rx_shift_q    <= rx_shift_d;
         tx_shift_q    <= tx_shift_d;
         byte_done_q   <= byte_done_d;
         rx_data_q     <= rx_data_d;
         rx_valid_q    <= rx_valid_d;
         tx_underrun_q <= tx_underrun_d;
         hold_q        <= hold_d;
         hold_full_q   <= hold_full_d;
      end
   end

   assign spi_miso    = tx_shift_q[7];
   assign spi_miso_oe = (state_q == S_ACTIVE);
   assign busy        = (state_q == S_ACTIVE);
   assign tx_ready    = ~hold_full_q;
   assign rx_data     = rx_data_q;
   assign rx_valid    = rx_valid_q;
   assign tx_underrun = tx_underrun_q;

endmodule

// File: tb/tb_spi_target.sv
// Self-checking bench for spi_target: acts as an SPI mode-0 master and host-side writer.
`timescale 1ns/1ps
module tb_spi_target;

   localparam int HALF = 6;

   logic       CLK = 1'b0;
   logic       reset;
   logic       spi_sck, spi_ss_n, spi_mosi;
   logic       spi_miso, spi_miso_oe;
   logic [7:0] tx_data;
   logic       tx_valid, tx_ready;
   logic [7:0] rx_data;
   logic       rx_valid, tx_underrun, busy;

   spi_target #(.SYNC_STAGES(2), .IDLE_BYTE(8'hFF)) dut (
      .CLK(CLK), .reset(reset), .spi_sck(spi_sck), .spi_ss_n(spi_ss_n),
      .spi_mosi(spi_mosi), .spi_miso(spi_miso), .spi_miso_oe(spi_miso_oe),
      .tx_data(tx_data), .tx_valid(tx_valid), .tx_ready(tx_ready),
      .rx_data(rx_data), .rx_valid(rx_valid), .tx_underrun(tx_underrun), .busy(busy)
   );

   always #5 CLK = ~CLK;

   int n_tests = 0;
   int n_fail  = 0;
   int und_cnt = 0;
   int rx_cnt  = 0;
   logic [7:0] rx_q[$];
   logic [7:0] miso_q[$];

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   // scoreboard side: received bytes are popped as the DUT strobes them
   always @(posedge CLK) begin
      #1;
      if (!reset && tx_underrun) und_cnt++;
      if (!reset && rx_valid) begin
         rx_cnt++;
         if (rx_q.size() == 0) begin
            n_tests++;
            n_fail++;
            $display("FAIL rx_unexpected: got %0h expected no strobe at %0t", rx_data, $time);
         end else begin
            check("rx_data", {24'h0, rx_data}, {24'h0, rx_q.pop_front()});
         end
      end
   end

   initial begin
      #2000000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "timeout");
   end

   task automatic tick(input int n);
      repeat (n) @(negedge CLK);
   endtask

   task automatic host_write(input logic [7:0] d);
      tx_valid = 1'b1;
      tx_data  = d;
      tick(1);
      tx_valid = 1'b0;
   endtask

   task automatic select_bus();
      spi_ss_n = 1'b0;
      tick(8);
   endtask

   task automatic deselect_bus();
      tick(HALF);
      spi_ss_n = 1'b1;
      tick(10);
      check("rx_missing", rx_q.size(), 0);
   endtask

   // full byte: MOSI pushed to the scoreboard, MISO sampled just before each rise
   task automatic xfer(input logic [7:0] mosi_b, input logic [7:0] exp_miso);
      logic [7:0] got;
      rx_q.push_back(mosi_b);
      miso_q.push_back(exp_miso);
      got = 8'h00;
      for (int i = 7; i >= 0; i--) begin
         spi_mosi = mosi_b[i];
         tick(HALF);
         got = {got[6:0], spi_miso};
         spi_sck = 1'b1;
         tick(HALF);
         spi_sck = 1'b0;
      end
      check("miso_byte", {24'h0, got}, {24'h0, miso_q.pop_front()});
   endtask

   task automatic partial(input logic [7:0] mosi_b, input int n, input bit end_high);
      for (int i = 0; i < n; i++) begin
         spi_mosi = mosi_b[7-i];
         tick(HALF);
         spi_sck = 1'b1;
         if (!(end_high && i == n - 1)) begin
            tick(HALF);
            spi_sck = 1'b0;
         end
      end
   endtask

   task automatic check_reset_outputs(input string tag);
      check({tag, "_miso"},     spi_miso, 1);
      check({tag, "_oe"},       spi_miso_oe, 0);
      check({tag, "_tx_ready"}, tx_ready, 1);
      check({tag, "_rx_data"},  rx_data, 0);
      check({tag, "_rx_valid"}, rx_valid, 0);
      check({tag, "_underrun"}, tx_underrun, 0);
      check({tag, "_busy"},     busy, 0);
   endtask

   typedef struct {
      logic [7:0] mosi;
      bit         pre;
      logic [7:0] pre_data;
      logic [7:0] exp_miso;
      int         exp_und;
   } vec_t;

   vec_t vecs[5];
   int   u0, r0;

   initial begin
      vecs[0] = '{mosi: 8'hA5, pre: 1'b0, pre_data: 8'h00, exp_miso: 8'hFF, exp_und: 1};
      vecs[1] = '{mosi: 8'h00, pre: 1'b1, pre_data: 8'h3C, exp_miso: 8'h3C, exp_und: 0};
      vecs[2] = '{mosi: 8'h5A, pre: 1'b1, pre_data: 8'hC3, exp_miso: 8'hC3, exp_und: 0};
      vecs[3] = '{mosi: 8'hFF, pre: 1'b1, pre_data: 8'h00, exp_miso: 8'h00, exp_und: 0};
      vecs[4] = '{mosi: 8'h81, pre: 1'b0, pre_data: 8'h00, exp_miso: 8'hFF, exp_und: 1};

      reset = 1'b1; spi_sck = 1'b0; spi_ss_n = 1'b1; spi_mosi = 1'b0;
      tx_valid = 1'b0; tx_data = 8'h00;
      tick(3);
      check_reset_outputs("rst");
      reset = 1'b0;
      tick(6);

      // single-byte vectors
      foreach (vecs[k]) begin
         u0 = und_cnt;
         if (vecs[k].pre) begin
            host_write(vecs[k].pre_data);
            check("ready_after_write", tx_ready, 0);
         end
         select_bus();
         check("busy_sel", busy, 1);
         check("oe_sel", spi_miso_oe, 1);
         check("ready_after_load", tx_ready, 1);
         check("und_at_select", und_cnt - u0, vecs[k].exp_und);
         xfer(vecs[k].mosi, vecs[k].exp_miso);
         check("und_in_byte", und_cnt - u0, vecs[k].exp_und);
         deselect_bus();
         check("rx_data_hold", rx_data, vecs[k].mosi);
         check("busy_desel", busy, 0);
      end

      // three back-to-back bytes, second byte written while byte 1 is in flight
      host_write(8'h11);
      r0 = rx_cnt;
      select_bus();
      host_write(8'h22);
      check("ready_full_b1", tx_ready, 0);
      u0 = und_cnt;
      xfer(8'h01, 8'h11);
      xfer(8'h02, 8'h22);
      check("und_b2", und_cnt - u0, 0);
      xfer(8'h03, 8'hFF);
      check("und_b3", und_cnt - u0, 1);
      deselect_bus();
      check("rx_count_3", rx_cnt - r0, 3);

      // partial byte discarded
      r0 = rx_cnt;
      select_bus();
      partial(8'hB7, 5, 1'b0);
      deselect_bus();
      check("partial_no_rx", rx_cnt - r0, 0);
      check("partial_rx_data", rx_data, 8'h03);
      select_bus();
      xfer(8'h7E, 8'hFF);
      deselect_bus();
      check("after_partial", rx_data, 8'h7E);

      // reset mid-byte with the holding register full
      host_write(8'hC3);
      select_bus();
      host_write(8'h96);
      check("ready_full_pre_rst", tx_ready, 0);
      partial(8'hE1, 4, 1'b1);
      reset = 1'b1;
      tick(2);
      check_reset_outputs("midrst");
      reset = 1'b0;
      tick(12);
      check("desel_after_rst", busy, 0);
      check("oe_after_rst", spi_miso_oe, 0);
      spi_sck = 1'b0;
      spi_ss_n = 1'b1;
      tick(10);
      r0 = rx_cnt;
      select_bus();
      xfer(8'h55, 8'hFF);
      deselect_bus();
      check("rx_after_rst", rx_data, 8'h55);
      check("rx_count_rst", rx_cnt - r0, 1);

      // host write landing exactly on the select load cycle
      u0 = und_cnt;
      spi_ss_n = 1'b0;
      tick(3);
      tx_valid = 1'b1;
      tx_data  = 8'h5A;
      tick(1);
      tx_valid = 1'b0;
      tick(1);
      check("coinc_ready", tx_ready, 0);
      check("coinc_und", und_cnt - u0, 1);
      tick(3);
      xfer(8'h00, 8'hFF);
      xfer(8'h00, 8'h5A);
      check("coinc_und_b2", und_cnt - u0, 1);
      check("coinc_ready_b2", tx_ready, 1);
      deselect_bus();

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
